// File: rtl/tag_nios_system_nios2_gen2_0_cpu_ocimem_arbiter.sv
// rtl/tag_nios_system_nios2_gen2_0_cpu_ocimem_arbiter.sv - OCI debug RAM arbiter, CPU Avalon slave vs JTAG pointer port
module tag_nios_system_nios2_gen2_0_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              debugack,
  input  logic              jtag_addr_ld,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [31:0]       jtag_wdata,
  output logic [31:0]       jtag_rdata,
  output logic              jtag_done,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {IDLE, RD_CPU, RD_JTAG} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              pend_q, pend_d;
  logic              wr_q, wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              last_jtag_q, last_jtag_d;

  logic cpu_req, jtag_want, grant_cpu, grant_jtag, cpu_complete, jtag_complete, busy;

  always_comb begin
    cpu_req    = avs_read | avs_write;
    // busy stays high through the done cycle so a req there counts as overrun
    busy       = pend_q | done_q;
    jtag_want  = pend_q && (state_q == IDLE);
    grant_cpu  = 1'b0;
    grant_jtag = 1'b0;
    if (reset_n && state_q == IDLE) begin
      if (jtag_want && cpu_req) begin
        if (debugack || !last_jtag_q) grant_jtag = 1'b1;
        else                          grant_cpu  = 1'b1;
      end else if (jtag_want) begin
        grant_jtag = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end
    end

    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    ram_wdata = 32'h0;
    if (grant_cpu) begin
      ram_addr = avs_address;
      ram_be   = avs_byteenable;
      if (avs_write) begin
        ram_we    = 1'b1;
        ram_wdata = avs_writedata;
      end
    end else if (grant_jtag) begin
      ram_addr = ptr_q;
      if (wr_q) begin
        ram_we    = 1'b1;
        ram_be    = 4'hF;
        ram_wdata = wdata_q;
      end
    end

    cpu_complete    = (grant_cpu && avs_write) || (state_q == RD_CPU);
    avs_waitrequest = cpu_req & ~cpu_complete;
    avs_readdata    = (state_q == RD_CPU) ? ram_rdata : 32'h0;
    jtag_complete   = (grant_jtag && wr_q) || (state_q == RD_JTAG);

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_cpu && avs_read)     state_d = RD_CPU;
        else if (grant_jtag && !wr_q)  state_d = RD_JTAG;
      end
      RD_CPU:  state_d = IDLE;
      RD_JTAG: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    last_jtag_d = last_jtag_q;
    if (grant_jtag)     last_jtag_d = 1'b1;
    else if (grant_cpu) last_jtag_d = 1'b0;

    pend_d  = pend_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    if (jtag_complete) pend_d = 1'b0;
    if (jtag_req && !busy) begin
      pend_d  = 1'b1;
      wr_d    = jtag_wr;
      wdata_d = jtag_wdata;
    end
    ovr_d = ovr_q | (jtag_req & busy);

    ptr_d = ptr_q;
    if (jtag_addr_ld)       ptr_d = jtag_addr;
    else if (jtag_complete) ptr_d = ptr_q + ADDR_W'(1);

    rdata_d = rdata_q;
    if (state_q == RD_JTAG) rdata_d = ram_rdata;
    done_d = jtag_complete;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      pend_q      <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      last_jtag_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pend_q      <= pend_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      last_jtag_q <= last_jtag_d;
    end
  end

  assign jtag_rdata   = rdata_q;
  assign jtag_done    = done_q;
  assign jtag_busy    = busy;
  assign jtag_overrun = ovr_q;

endmodule

// File: tb/tb_tag_nios_system_nios2_gen2_0_cpu_ocimem_arbiter.sv
// tb/tb_tag_nios_system_nios2_gen2_0_cpu_ocimem_arbiter.sv - scoreboard bench with RAM model and reference memory
module tb_tag_nios_system_nios2_gen2_0_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        debugack;
  logic        jtag_addr_ld;
  logic [7:0]  jtag_addr;
  logic        jtag_req;
  logic        jtag_wr;
  logic [31:0] jtag_wdata;
  logic [31:0] jtag_rdata;
  logic        jtag_done;
  logic        jtag_busy;
  logic        jtag_overrun;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  tag_nios_system_nios2_gen2_0_cpu_ocimem_arbiter #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .debugack(debugack),
    .jtag_addr_ld(jtag_addr_ld), .jtag_addr(jtag_addr), .jtag_req(jtag_req),
    .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata), .jtag_rdata(jtag_rdata),
    .jtag_done(jtag_done), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t        jq[$];
  exp_t        cq[$];
  logic [31:0] ram[256];
  logic [31:0] ref_mem[256];
  logic [7:0]  mptr;
  int          cyc = 0;
  int          done_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ram[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
    ram_rdata <= ram[ram_addr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (jtag_done) begin
        exp_t e;
        done_cnt++;
        if (jq.size() == 0) check("jtag_done_unexpected", 32'd1, 32'd0);
        else begin
          e = jq.pop_front();
          if (e.rd) check("jtag_rdata", jtag_rdata, e.data);
        end
      end
      if ((avs_read || avs_write) && !avs_waitrequest) begin
        exp_t c;
        if (cq.size() == 0) check("cpu_complete_unexpected", 32'd1, 32'd0);
        else begin
          c = cq.pop_front();
          if (c.rd) check("avs_readdata", avs_readdata, c.data);
        end
      end
    end
  end

  task automatic jtag_load(input logic [7:0] a);
    @(posedge clk); #1;
    jtag_addr_ld = 1'b1; jtag_addr = a; mptr = a;
    @(posedge clk); #1;
    jtag_addr_ld = 1'b0;
  endtask

  task automatic jtag_access(input bit ld, input logic [7:0] a, input bit wr,
                             input logic [31:0] d, input int exp_lat, input string nm);
    exp_t e;
    int   t0;
    bit   seen;
    @(posedge clk); #1;
    jtag_req = 1'b1; jtag_wr = wr; jtag_wdata = d; jtag_addr_ld = ld; jtag_addr = a;
    if (ld) mptr = a;
    e.rd   = !wr;
    e.data = wr ? 32'h0 : ref_mem[mptr];
    if (wr) ref_mem[mptr] = d;
    mptr = mptr + 8'd1;
    jq.push_back(e);
    t0 = cyc;
    @(posedge clk); #1;
    jtag_req = 1'b0; jtag_addr_ld = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (jtag_done) seen = 1'b1;
    end
    if (!seen) check({nm, "_timeout"}, 32'd0, 32'd1);
    else if (exp_lat >= 0) check(nm, 32'(cyc - t0), 32'(exp_lat));
  endtask

  task automatic cpu_access(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, input int exact_ws, input string nm);
    exp_t c;
    int   ws;
    bit   fin;
    @(posedge clk); #1;
    avs_address = a; avs_read = !wr; avs_write = wr; avs_writedata = d; avs_byteenable = be;
    c.rd   = !wr;
    c.data = wr ? 32'h0 : ref_mem[a];
    if (wr) ref_mem[a] = merge(ref_mem[a], d, be);
    cq.push_back(c);
    ws = 0; fin = 1'b0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) fin = 1'b1;
      else ws++;
    end
    if (!fin) check({nm, "_timeout"}, 32'd0, 32'd1);
    else if (exact_ws >= 0) check(nm, 32'(ws), 32'(exact_ws));
    else check({nm, "_ws_le2"}, 32'(ws <= 2), 32'd1);
  endtask

  task automatic cpu_idle();
    @(posedge clk); #1;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    mptr = 8'h00;
    reset_n = 1'b0; debugack = 1'b0;
    jtag_addr_ld = 1'b0; jtag_addr = 8'h0; jtag_req = 1'b0; jtag_wr = 1'b0; jtag_wdata = 32'h0;
    avs_address = 8'h80; avs_read = 1'b1; avs_write = 1'b0; avs_writedata = 32'h0; avs_byteenable = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_waitrequest_follows_req", {31'h0, avs_waitrequest}, 32'd1);
    check("rst_ram_we", {31'h0, ram_we}, 32'd0);
    check("rst_ram_addr", {24'h0, ram_addr}, 32'd0);
    check("rst_ram_be", {28'h0, ram_be}, 32'd0);
    check("rst_jtag_busy", {31'h0, jtag_busy}, 32'd0);
    check("rst_jtag_done", {31'h0, jtag_done}, 32'd0);
    check("rst_jtag_overrun", {31'h0, jtag_overrun}, 32'd0);
    check("rst_jtag_rdata", jtag_rdata, 32'd0);
    check("rst_avs_readdata", avs_readdata, 32'd0);
    avs_read = 1'b0;
    #1;
    check("rst_waitrequest_idle", {31'h0, avs_waitrequest}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    jtag_load(8'h10);
    jtag_access(0, 8'h0, 1, 32'hCAFE0001, 2, "jwr_lat");
    jtag_access(0, 8'h0, 1, 32'hCAFE0002, 2, "jwr_lat");
    check("ram_0x10", ram[8'h10], 32'hCAFE0001);
    check("ram_0x11", ram[8'h11], 32'hCAFE0002);
    jtag_load(8'h10);
    jtag_access(0, 8'h0, 0, 32'h0, 3, "jrd_lat");
    jtag_access(0, 8'h0, 0, 32'h0, 3, "jrd_lat");
    jtag_access(1, 8'h20, 0, 32'h0, 3, "jrd_ld_same_cycle");

    jtag_load(8'hFF);
    jtag_access(0, 8'h0, 1, 32'h1, 2, "wrap_wr");
    jtag_access(0, 8'h0, 1, 32'h2, 2, "wrap_wr");
    check("ram_0xff", ram[8'hFF], 32'h1);
    check("ram_0x00", ram[8'h00], 32'h2);
    jtag_access(0, 8'h0, 0, 32'h0, 3, "wrap_ptr_rd");

    fork
      jtag_access(0, 8'h0, 1, 32'h5A5A0001, 4, "tie_jwr_lat");
      begin
        @(posedge clk);
        cpu_access(0, 8'h90, 32'h0, 4'hF, 1, "tie_cpu_first_ws");
        cpu_access(0, 8'h91, 32'h0, 4'hF, 2, "tie_cpu_second_ws");
        cpu_idle();
      end
    join

    debugack = 1'b1;
    fork
      jtag_access(0, 8'h0, 0, 32'h0, 3, "dbg_jrd_lat");
      begin
        @(posedge clk);
        cpu_access(1, 8'hA0, 32'h12345678, 4'hF, 2, "dbg_cpu_wr_ws");
        cpu_idle();
      end
    join
    check("ram_0xa0", ram[8'hA0], 32'h12345678);
    debugack = 1'b0;

    fork
      begin
        for (int i = 0; i < 20; i++) begin
          bit wr;
          wr = 1'($urandom_range(0, 1));
          cpu_access(wr, 8'(8'h80 + $urandom_range(0, 63)), $urandom,
                     wr ? 4'($urandom_range(1, 15)) : 4'hF, -1, "rnd_cpu");
          if ($urandom_range(0, 2) == 0) cpu_idle();
        end
        cpu_idle();
      end
      begin
        jtag_load(8'h30);
        for (int i = 0; i < 12; i++) begin
          bit ld;
          ld = ($urandom_range(0, 3) == 0);
          jtag_access(ld, 8'(8'h30 + $urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      $urandom, -1, "rnd_jtag");
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
    join

    @(posedge clk); #1;
    d0 = done_cnt;
    jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr_ld = 1'b1; jtag_addr = 8'h40;
    jq.push_back('{rd: 1'b1, data: ref_mem[8'h40]});
    mptr = 8'h41;
    @(posedge clk); #1;
    jtag_req = 1'b0; jtag_addr_ld = 1'b0;
    @(posedge clk); #1;
    jtag_req = 1'b1;
    @(posedge clk); #1;
    jtag_req = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("ovr_single_done", 32'(done_cnt - d0), 32'd1);
    check("ovr_flag", {31'h0, jtag_overrun}, 32'd1);
    jtag_access(0, 8'h0, 0, 32'h0, 3, "ovr_next_rd");
    check("ovr_sticky", {31'h0, jtag_overrun}, 32'd1);

    @(posedge clk); #1;
    jtag_req = 1'b1; jtag_wr = 1'b0;
    @(posedge clk); #1;
    jtag_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    check("mrst_busy", {31'h0, jtag_busy}, 32'd0);
    check("mrst_done", {31'h0, jtag_done}, 32'd0);
    check("mrst_overrun", {31'h0, jtag_overrun}, 32'd0);
    check("mrst_rdata", jtag_rdata, 32'd0);
    check("mrst_ram_we", {31'h0, ram_we}, 32'd0);
    check("mrst_ram_addr", {24'h0, ram_addr}, 32'd0);
    check("mrst_ram_wdata", ram_wdata, 32'd0);
    check("mrst_avs_readdata", avs_readdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    mptr = 8'h00;
    jtag_access(0, 8'h0, 0, 32'h0, 3, "mrst_ptr_zero_rd");

    repeat (3) @(posedge clk);
    check("jq_drained", 32'(jq.size()), 32'd0);
    check("cq_drained", 32'(cq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
